tlul_reg_arbiter: RTL and testbench

//  Shares one register-interface port (re/we/addr/wdata/be/busy/rdata/error) between NumReq

---
 rtl/tlul_reg_arbiter_if.sv | 26 ++
 rtl/tlul_reg_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_tlul_reg_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tlul_reg_arbiter_if.sv
// Register-target bus between tlul_reg_arbiter (master) and a register block (slave).
interface tlul_reg_arbiter_if #(
    parameter int unsigned RegAw = 8,
    parameter int unsigned RegDw = 32
) ();
    localparam int unsigned RegBw = RegDw / 8;

    logic             re;
    logic             we;
    logic [RegAw-1:0] addr;
    logic [RegDw-1:0] wdata;
    logic [RegBw-1:0] be;
    logic             busy;
    logic [RegDw-1:0] rdata;
    logic             error;

    modport master (
        output re, we, addr, wdata, be,
        input  busy, rdata, error
    );

    modport slave (
        input  re, we, addr, wdata, be,
        output busy, rdata, error
    );
endinterface

// File: rtl/tlul_reg_arbiter.sv
// Round-robin arbiter sharing one register port between NumReq request/response masters.
// Optional busy watchdog enabled by defining TLUL_REG_ARB_TIMEOUT_EN.
module tlul_reg_arbiter #(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned RegAw         = 8,
    parameter int unsigned RegDw         = 32,
    parameter int unsigned AccessLatency = 0,
    parameter int unsigned TimeoutCycles = 64
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NumReq-1:0]                  req_valid_i,
    output logic [NumReq-1:0]                  req_ready_o,
    input  logic [NumReq-1:0]                  req_write_i,
    input  logic [NumReq-1:0][RegAw-1:0]       req_addr_i,
    input  logic [NumReq-1:0][RegDw-1:0]       req_wdata_i,
    input  logic [NumReq-1:0][RegDw/8-1:0]     req_be_i,
    output logic [NumReq-1:0]                  rsp_valid_o,
    input  logic [NumReq-1:0]                  rsp_ready_i,
    output logic [RegDw-1:0]                   rsp_rdata_o,
    output logic                               rsp_error_o,
    tlul_reg_arbiter_if.master                 reg_if
);
    localparam int unsigned RegBw = RegDw / 8;
    localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e           state_q, state_d;
    logic [IdxW-1:0]  rr_q, rr_d;
    logic [IdxW-1:0]  gnt_q, gnt_d;
    logic             write_q, write_d;
    logic [RegAw-1:0] addr_q, addr_d;
    logic [RegDw-1:0] wdata_q, wdata_d;
    logic [RegBw-1:0] be_q, be_d;
    logic [RegDw-1:0] rdata_q, rdata_d;
    logic             error_q, error_d;

    logic             gnt_found;
    logic [IdxW-1:0]  gnt_idx;
    logic [RegDw-1:0] capt_rdata;

`ifdef TLUL_REG_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^32'(TimeoutCycles);
`endif

    // Two passes: lowest valid index at/after rr_q, else lowest valid index overall (wrap).
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (!gnt_found && req_valid_i[k] && (32'(rr_q) <= k)) begin
                gnt_found = 1'b1;
                gnt_idx   = IdxW'(k);
            end
        end
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (!gnt_found && req_valid_i[k]) begin
                gnt_found = 1'b1;
                gnt_idx   = IdxW'(k);
            end
        end
    end

    assign capt_rdata = (write_q || reg_if.error) ? '1 : reg_if.rdata;

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        gnt_d        = gnt_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        rdata_d      = rdata_q;
        error_d      = error_q;
        req_ready_o  = '0;
        rsp_valid_o  = '0;
        rsp_rdata_o  = '0;
        rsp_error_o  = 1'b0;
        reg_if.re    = 1'b0;
        reg_if.we    = 1'b0;
        reg_if.addr  = '0;
        reg_if.wdata = '0;
        reg_if.be    = '0;
`ifdef TLUL_REG_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (gnt_found) begin
                    req_ready_o = NumReq'(1) << gnt_idx;
                    gnt_d       = gnt_idx;
                    write_d     = req_write_i[gnt_idx];
                    addr_d      = req_addr_i[gnt_idx];
                    wdata_d     = req_wdata_i[gnt_idx];
                    be_d        = req_be_i[gnt_idx];
`ifdef TLUL_REG_ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                    state_d     = StIssue;
                end
            end
            StIssue: begin
                reg_if.addr  = {addr_q[RegAw-1:2], 2'b00};
                reg_if.wdata = wdata_q;
                reg_if.be    = be_q;
                if (!reg_if.busy) begin
                    reg_if.re = !write_q;
                    reg_if.we = write_q;
                    if (AccessLatency == 0) begin
                        rdata_d = capt_rdata;
                        error_d = reg_if.error;
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                    end
                end
`ifdef TLUL_REG_ARB_TIMEOUT_EN
                else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                    rdata_d = '1;
                    error_d = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StWait: begin
                rdata_d = capt_rdata;
                error_d = reg_if.error;
                state_d = StResp;
            end
            StResp: begin
                rsp_valid_o = NumReq'(1) << gnt_q;
                rsp_rdata_o = rdata_q;
                rsp_error_o = error_q;
                if (rsp_ready_i[gnt_q]) begin
                    state_d = StIdle;
                    rr_d    = (32'(gnt_q) == NumReq - 1) ? '0 : gnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            rr_q    <= '0;
            gnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
`ifdef TLUL_REG_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
`ifdef TLUL_REG_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_tlul_reg_arbiter.sv
// Self-checking bench for tlul_reg_arbiter (NumReq=2, AccessLatency=1) with a
// transaction-level round-robin reference model.
module tb_tlul_reg_arbiter;
    localparam int NR = 2;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int BW = DW / 8;
`ifdef TLUL_REG_ARB_TIMEOUT_EN
    localparam int unsigned TO = 4;
    localparam int BusyLen = 3;
`else
    localparam int unsigned TO = 64;
    localparam int BusyLen = 5;
`endif

    logic                   clk;
    logic                   rst;
    logic [NR-1:0]          req_valid;
    logic [NR-1:0]          req_ready;
    logic [NR-1:0]          req_write;
    logic [NR-1:0][AW-1:0]  req_addr;
    logic [NR-1:0][DW-1:0]  req_wdata;
    logic [NR-1:0][BW-1:0]  req_be;
    logic [NR-1:0]          rsp_valid;
    logic [NR-1:0]          rsp_ready;
    logic [DW-1:0]          rsp_rdata;
    logic                   rsp_error;

    int n_tests = 0;
    int n_fail  = 0;
    int rr_m    = 0;

    tlul_reg_arbiter_if #(.RegAw(AW), .RegDw(DW)) reg_if ();

    tlul_reg_arbiter #(
        .NumReq        (NR),
        .RegAw         (AW),
        .RegDw         (DW),
        .AccessLatency (1),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_be_i    (req_be),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_error_o (rsp_error),
        .reg_if      (reg_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        for (int i = 0; i < NR; i++) begin
            req_write[i] = 1'($urandom);
            req_addr[i]  = AW'($urandom);
            req_wdata[i] = DW'($urandom);
            req_be[i]    = BW'($urandom);
        end
    endtask

    // Round-robin rule: first valid index at or after the pointer, wrapping.
    function automatic int exp_grant(input logic [NR-1:0] vm);
        for (int i = 0; i < NR; i++) begin
            if (vm[(rr_m + i) % NR]) return (rr_m + i) % NR;
        end
        return -1;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_strobe"}, 64'({reg_if.re, reg_if.we}), 64'(0));
        chk({tag, "_addr"}, 64'(reg_if.addr), 64'(0));
        chk({tag, "_wdata"}, 64'(reg_if.wdata), 64'(0));
        chk({tag, "_be"}, 64'(reg_if.be), 64'(0));
        chk({tag, "_rspv"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(0));
        chk({tag, "_err"}, 64'(rsp_error), 64'(0));
    endtask

    task automatic run_txn(input logic [NR-1:0] vm, input logic wr, input logic [AW-1:0] ad,
                           input logic [DW-1:0] wd, input logic [BW-1:0] b,
                           input logic [DW-1:0] rd, input logic er,
                           input int nbusy, input int nwait);
        int            g;
        logic [DW-1:0] exp_rd;
        g = exp_grant(vm);
        // Accept cycle
        tick();
        rsp_ready = '0;
        req_valid = vm;
        scramble();
        req_write[g] = wr;
        req_addr[g]  = ad;
        req_wdata[g] = wd;
        req_be[g]    = b;
        reg_if.busy  = 1'($urandom);
        reg_if.rdata = DW'($urandom);
        reg_if.error = 1'b0;
        settle();
        chk("grant", 64'(req_ready), 64'(NR'(1) << g));
        chk("idle_strobe", 64'({reg_if.re, reg_if.we}), 64'(0));
        chk("idle_rsp", 64'(rsp_valid), 64'(0));
        // Issue cycles, payload inputs scrambled to prove it was latched
        for (int c = 0; c <= nbusy; c++) begin
            tick();
            req_valid    = NR'($urandom);
            scramble();
            reg_if.busy  = (c < nbusy);
            reg_if.rdata = DW'($urandom);
            reg_if.error = 1'($urandom);
            settle();
            chk("issue_no_grant", 64'(req_ready), 64'(0));
            chk("issue_addr", 64'(reg_if.addr), 64'({ad[AW-1:2], 2'b00}));
            chk("issue_strobe", 64'({reg_if.re, reg_if.we}),
                64'((c < nbusy) ? 2'b00 : (wr ? 2'b01 : 2'b10)));
            chk("issue_rsp", 64'(rsp_valid), 64'(0));
            if (c == nbusy) begin
                chk("issue_wdata", 64'(reg_if.wdata), 64'(wd));
                chk("issue_be", 64'(reg_if.be), 64'(b));
            end
        end
        // Data phase one cycle after the strobe
        tick();
        req_valid    = NR'($urandom);
        reg_if.busy  = 1'($urandom);
        reg_if.rdata = rd;
        reg_if.error = er;
        settle();
        chk("wait_strobe", 64'({reg_if.re, reg_if.we}), 64'(0));
        chk("wait_addr", 64'(reg_if.addr), 64'(0));
        chk("wait_rsp", 64'(rsp_valid), 64'(0));
        chk("wait_no_grant", 64'(req_ready), 64'(0));
        exp_rd = (wr || er) ? '1 : rd;
        for (int c = 0; c <= nwait; c++) begin
            tick();
            req_valid    = NR'($urandom);
            reg_if.busy  = 1'($urandom);
            reg_if.rdata = DW'($urandom);
            reg_if.error = 1'($urandom);
            rsp_ready    = (c < nwait) ? (NR'($urandom) & ~(NR'(1) << g)) : (NR'(1) << g);
            settle();
            chk("rsp_valid", 64'(rsp_valid), 64'(NR'(1) << g));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
            chk("rsp_error", 64'(rsp_error), 64'(er));
            chk("rsp_no_grant", 64'(req_ready), 64'(0));
        end
        rr_m = (g + 1) % NR;
    endtask

    initial begin
        rst          = 1'b1;
        req_valid    = '0;
        rsp_ready    = '0;
        req_write    = '0;
        req_addr     = '0;
        req_wdata    = '0;
        req_be       = '0;
        reg_if.busy  = 1'b0;
        reg_if.rdata = '0;
        reg_if.error = 1'b0;
        repeat (2) tick();
        tick();
        rst = 1'b0;
        settle();
        chk_all_zero("reset");

        // Single read, unaligned address
        run_txn(2'b01, 1'b0, 8'h13, 32'h0, 4'hF, 32'hCAFE0001, 1'b0, 0, 0);
        // Write with error in the data phase
        run_txn(2'b10, 1'b1, 8'h20, 32'h12345678, 4'h3, 32'h00005555, 1'b1, 0, 1);
        // Both masters continuously valid: grants alternate
        for (int i = 0; i < 4; i++) begin
            chk("alt_model", 64'(exp_grant(2'b11)), 64'(i % 2));
            run_txn(2'b11, 1'($urandom), AW'($urandom), DW'($urandom), BW'($urandom),
                    DW'($urandom), 1'b0, 0, 0);
        end
        // Target stall before the strobe
        run_txn(2'b11, 1'b0, 8'h84, 32'h0, 4'hF, 32'hA5A5_0F0F, 1'b0, BusyLen, 0);

        // Reset while waiting for read data drops the transaction and the pointer
        tick();
        req_valid    = 2'b10;
        scramble();
        req_write[1] = 1'b0;
        req_addr[1]  = 8'h58;
        reg_if.busy  = 1'b0;
        settle();
        chk("rst_grant", 64'(req_ready), 64'(2'b10));
        tick();
        req_valid = '0;
        settle();
        chk("rst_strobe", 64'({reg_if.re, reg_if.we}), 64'(2'b10));
        tick();
        rst          = 1'b1;
        reg_if.rdata = 32'h1111_2222;
        settle();
        tick();
        rst = 1'b0;
        settle();
        chk_all_zero("rst_wait");
        rr_m = 0;
        run_txn(2'b11, 1'b0, 8'h0C, 32'h0, 4'hF, 32'h7777_8888, 1'b0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            run_txn(NR'($urandom_range(1, 3)), 1'($urandom), AW'($urandom), DW'($urandom),
                    BW'($urandom), DW'($urandom), ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 2), $urandom_range(0, 2));
        end

`ifdef TLUL_REG_ARB_TIMEOUT_EN
        // Stuck target: watchdog ends the transaction with an error
        tick();
        rsp_ready    = '0;
        req_valid    = NR'(1) << rr_m;
        scramble();
        req_write[rr_m] = 1'b0;
        settle();
        chk("to_grant", 64'(req_ready), 64'(NR'(1) << rr_m));
        for (int c = 0; c < int'(TO); c++) begin
            tick();
            req_valid   = '0;
            reg_if.busy = 1'b1;
            settle();
            chk("to_strobe", 64'({reg_if.re, reg_if.we}), 64'(0));
            chk("to_no_rsp", 64'(rsp_valid), 64'(0));
        end
        tick();
        rsp_ready = NR'(1) << rr_m;
        settle();
        chk("to_rsp_valid", 64'(rsp_valid), 64'(NR'(1) << rr_m));
        chk("to_rsp_error", 64'(rsp_error), 64'(1));
        chk("to_rsp_rdata", 64'(rsp_rdata), 64'(32'hFFFF_FFFF));
        chk("to_strobe_end", 64'({reg_if.re, reg_if.we}), 64'(0));
`endif

        tick();
        rsp_ready = '0;
        req_valid = '0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
